// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter_if
//  Description : Bundles the requester-side handshake and the transmitter
//                control signals of uart_tx_arbiter.
//                  req        : per-requester byte request (level)
//                  req_data   : byte i at [8i+7:8i]
//                  req_ack    : one-cycle capture pulse per requester
//                  tx_start   : one-cycle start pulse to the UART
//                  tx_data    : registered byte for the UART
//                  tx_busy    : UART busy, start bit through stop bit
//                  grant_id   : last/current granted requester
//                  active     : byte being sequenced
//                  timeout_err: sticky tx_busy timeout flag
//                Modport master = requesters + UART side, slave = arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ack;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic [1:0]           grant_id;
  logic                 active;
  logic                 timeout_err;

  modport master (
    output req,
    output req_data,
    output tx_busy,
    input  req_ack,
    input  tx_start,
    input  tx_data,
    input  grant_id,
    input  active,
    input  timeout_err
  );

  modport slave (
    input  req,
    input  req_data,
    input  tx_busy,
    output req_ack,
    output tx_start,
    output tx_data,
    output grant_id,
    output active,
    output timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Round-robin arbiter sharing one 8N1 UART transmitter between
//                up to four byte requesters. A grant captures one byte, acks
//                the requester, pulses tx_start, then follows tx_busy through
//                the frame before arbitrating again.
//  Ports       : clk  - system clock, rising edge
//                rst  - asynchronous active-high reset
//                bus  - uart_tx_arbiter_if.slave (req/req_data/req_ack,
//                       tx_start/tx_data/tx_busy, grant_id, active,
//                       timeout_err)
//  Option      : UART_ARB_TIMEOUT_EN - when defined, a byte whose tx_busy
//                does not rise within TIMEOUT_CYCLES cycles of tx_start is
//                abandoned and timeout_err is set (sticky until rst).
//                When undefined timeout_err is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  uart_tx_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [NUM_REQ-1:0]   r_req_ack;
  logic                 r_tx_start;
  logic [7:0]           r_tx_data;
  logic [1:0]           r_grant_id;
  logic [1:0]           r_rr_ptr;
  logic                 r_active;

  logic                 w_grant;
  logic                 w_grant_hit;
  logic [1:0]           w_grant_idx;
  logic [NUM_REQ-1:0]   w_ack_nxt;
  logic                 w_timeout;

  // --------------------------------------------------------------------------
  // Round-robin pick: first requester after rr_ptr, wrapping. Scanning from
  // the farthest candidate back to the nearest lets the nearest one win.
  // --------------------------------------------------------------------------
  always_comb begin
    int j;
    w_grant_hit = 1'b0;
    w_grant_idx = r_rr_ptr;
    for (int k = NUM_REQ; k >= 1; k--) begin
      j = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (bus.req[j]) begin
        w_grant_hit = 1'b1;
        w_grant_idx = 2'(j);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Optional tx_busy watchdog. The counter runs only while WAIT_BUSY persists
  // and is cleared on any other path, so every grant starts from zero.
  // --------------------------------------------------------------------------
`ifdef UART_ARB_TIMEOUT_EN
  localparam int                 c_to_w    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_to_w-1:0]  c_to_last = c_to_w'(TIMEOUT_CYCLES - 1);

  logic [c_to_w-1:0] r_to_cnt;
  logic              r_timeout_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (r_state == ST_WAIT_BUSY && w_state_nxt == ST_WAIT_BUSY) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end else begin
        r_to_cnt <= '0;
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign bus.timeout_err = r_timeout_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign bus.timeout_err  = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and grant decision
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A busy transmitter in IDLE is foreign traffic: hold off.
        if (!bus.tx_busy && w_grant_hit) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (bus.tx_busy) begin
          w_state_nxt = ST_WAIT_DONE;
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (r_to_cnt == c_to_last) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
`endif
      end
      ST_WAIT_DONE: begin
        if (!bus.tx_busy) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // One-hot ack for the granted requester only.
  always_comb begin
    w_ack_nxt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_ack_nxt[i] = w_grant && (w_grant_idx == 2'(i));
    end
  end

  // --------------------------------------------------------------------------
  // Registered outputs. tx_data and grant_id hold between captures.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_ack  <= '0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
      r_grant_id <= 2'd0;
      r_rr_ptr   <= 2'(NUM_REQ - 1);
      r_active   <= 1'b0;
    end else begin
      r_req_ack  <= w_ack_nxt;
      r_tx_start <= w_grant;
      r_active   <= (w_state_nxt != ST_IDLE);
      if (w_grant) begin
        r_tx_data  <= bus.req_data[8*w_grant_idx +: 8];
        r_grant_id <= w_grant_idx;
        r_rr_ptr   <= w_grant_idx;
      end
    end
  end

  assign bus.req_ack  = r_req_ack;
  assign bus.tx_start = r_tx_start;
  assign bus.tx_data  = r_tx_data;
  assign bus.grant_id = r_grant_id;
  assign bus.active   = r_active;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_arbiter
//  Description : Self-checking bench for uart_tx_arbiter. A transaction-level
//                reference model (outstanding byte, last grant, rotation
//                scan) predicts every cycle's outputs; directed scenarios and
//                a randomized requester/transmitter phase drive the DUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int N  = 2;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  bit         m_out;     // a byte is granted and its frame not yet finished
  bit         m_seen;    // tx_busy has been seen high for that byte
  int         m_wait;    // cycles spent waiting for tx_busy to rise
  bit         m_err;
  int         m_rr;      // last granted requester (rotation origin)
  int         m_gid;
  logic [7:0] m_txd;

  // Transmitter emulation
  bit         auto_tx;
  int         tx_dly;
  int         tx_len;

  logic [7:0] sent_q[$];

  task automatic model_reset();
    m_out  = 0;
    m_seen = 0;
    m_wait = 0;
    m_err  = 0;
    m_rr   = N - 1;
    m_gid  = 0;
    m_txd  = 8'h00;
    tx_dly = 0;
    tx_len = 0;
  endtask

  function automatic int pick(input logic [N-1:0] r);
    int res;
    res = -1;
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (m_rr + k) % N;
      if (r[j] && res < 0) res = j;
    end
    return res;
  endfunction

  // One clock: inputs as currently driven are seen at the posedge; outputs
  // are compared with the model at the following negedge.
  task automatic step();
    logic [N-1:0]   s_req;
    logic [8*N-1:0] s_data;
    logic           s_busy;
    int             id;
    bit             exp_grant;
    int             exp_ack;
    s_req  = bus.req;
    s_data = bus.req_data;
    s_busy = bus.tx_busy;
    @(posedge clk);
    @(negedge clk);
    id        = pick(s_req);
    exp_grant = !m_out && !s_busy && (id >= 0);
    exp_ack   = exp_grant ? (1 << id) : 0;
    check("tx_start", bus.tx_start, exp_grant);
    check("req_ack", bus.req_ack, exp_ack);
    if (exp_grant) begin
      m_out  = 1;
      m_seen = 0;
      m_wait = 0;
      m_rr   = id;
      m_gid  = id;
      m_txd  = s_data[8*id +: 8];
    end else if (m_out) begin
      if (!m_seen) begin
        if (s_busy) m_seen = 1;
`ifdef UART_ARB_TIMEOUT_EN
        else begin
          m_wait++;
          if (m_wait == TO) begin
            m_out = 0;
            m_err = 1;
          end
        end
`endif
      end else if (!s_busy) begin
        m_out = 0;
      end
    end
    check("tx_data", bus.tx_data, m_txd);
    check("grant_id", bus.grant_id, m_gid);
    check("active", bus.active, m_out);
    check("timeout_err", bus.timeout_err, m_err);
    if (bus.tx_start) sent_q.push_back(bus.tx_data);
    if (auto_tx) begin
      if (tx_dly > 0) begin
        tx_dly--;
        if (tx_dly == 0) begin
          bus.tx_busy = 1'b1;
          tx_len      = $urandom_range(1, 12);
        end
      end else if (tx_len > 0) begin
        tx_len--;
        if (tx_len == 0) bus.tx_busy = 1'b0;
      end
      if (bus.tx_start) tx_dly = $urandom_range(1, 3);
    end
  endtask

  task automatic apply_reset();
    rst         = 1'b1;
    bus.req     = '0;
    bus.tx_busy = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Finish a frame for the byte just granted, transmitter driven by hand.
  task automatic finish_frame();
    bus.req     = '0;
    bus.tx_busy = 1'b1;
    repeat (3) step();
    bus.tx_busy = 1'b0;
    repeat (2) step();
  endtask

  initial begin
    int cnt;
    rst          = 1'b1;
    bus.req      = '0;
    bus.req_data = '0;
    bus.tx_busy  = 1'b0;
    auto_tx      = 0;
    model_reset();
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_tx_start", bus.tx_start, 0);
    check("rst_req_ack", bus.req_ack, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_grant_id", bus.grant_id, 0);
    check("rst_active", bus.active, 0);
    check("rst_timeout_err", bus.timeout_err, 0);
    rst = 1'b0;
    step();

    // Single request, long frame
    bus.req           = 2'b01;
    bus.req_data[7:0] = 8'h41;
    step();
    check("t1_ack", bus.req_ack, 1);
    check("t1_start", bus.tx_start, 1);
    check("t1_data", bus.tx_data, 8'h41);
    check("t1_gid", bus.grant_id, 0);
    check("t1_active", bus.active, 1);
    bus.req = '0;
    step();
    bus.tx_busy = 1'b1;
    repeat (8680) step();
    check("t1_active_busy", bus.active, 1);
    bus.tx_busy = 1'b0;
    step();
    check("t1_active_low", bus.active, 0);
    step();

    // Both requesting: strict alternation from requester 0
    apply_reset();
    auto_tx      = 1;
    sent_q.delete();
    bus.req      = 2'b11;
    bus.req_data = {8'h31, 8'h30};
    cnt = 0;
    while (sent_q.size() < 4 && cnt < 400) begin
      step();
      cnt++;
    end
    bus.req = '0;
    check("t2_count", sent_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] exp_b;
      logic [7:0] got_b;
      exp_b = (i % 2 == 0) ? 8'h30 : 8'h31;
      got_b = (i < sent_q.size()) ? sent_q[i] : 8'hxx;
      check("t2_order", got_b, exp_b);
    end
    cnt = 0;
    while ((bus.active || bus.tx_busy) && cnt < 100) begin
      step();
      cnt++;
    end
    check("t2_drain", bus.active, 0);
    auto_tx     = 0;
    bus.tx_busy = 1'b0;
    step();

    // Foreign tx_busy blocks the grant
    bus.tx_busy       = 1'b1;
    bus.req           = 2'b01;
    bus.req_data[7:0] = 8'h77;
    cnt = 0;
    repeat (5) begin
      step();
      cnt += bus.tx_start;
    end
    check("t3_no_start", cnt, 0);
    bus.tx_busy = 1'b0;
    step();
    check("t3_start", bus.tx_start, 1);
    check("t3_data", bus.tx_data, 8'h77);
    finish_frame();

    // Reset in WAIT_DONE
    bus.req           = 2'b01;
    bus.req_data[7:0] = 8'h55;
    step();
    bus.req     = '0;
    bus.tx_busy = 1'b1;
    repeat (2) step();
    check("t4_data_before", bus.tx_data, 8'h55);
    #2 rst = 1'b1;
    #1;
    check("t4_tx_start", bus.tx_start, 0);
    check("t4_req_ack", bus.req_ack, 0);
    check("t4_tx_data", bus.tx_data, 0);
    check("t4_grant_id", bus.grant_id, 0);
    check("t4_active", bus.active, 0);
    model_reset();
    bus.tx_busy = 1'b0;
    @(negedge clk);
    rst               = 1'b0;
    bus.req           = 2'b01;
    bus.req_data[7:0] = 8'h66;
    step();
    check("t4_regrant_ack", bus.req_ack, 1);
    check("t4_regrant_data", bus.tx_data, 8'h66);
    finish_frame();

    // Short req[1] pulse while requester 0 is in flight
    bus.req           = 2'b01;
    bus.req_data[7:0] = 8'h12;
    step();
    bus.req = 2'b10;
    cnt = 0;
    step();
    cnt += bus.tx_start + bus.req_ack;
    bus.req     = '0;
    bus.tx_busy = 1'b1;
    step();
    cnt += bus.tx_start + bus.req_ack;
    bus.tx_busy = 1'b0;
    repeat (3) begin
      step();
      cnt += bus.tx_start + bus.req_ack;
    end
    check("t5_no_spurious", cnt, 0);

`ifdef UART_ARB_TIMEOUT_EN
    // tx_busy never rises
    apply_reset();
    bus.req           = 2'b01;
    bus.req_data[7:0] = 8'h5A;
    step();
    bus.req = '0;
    for (int i = 1; i <= TO; i++) begin
      step();
      check("t6_err", bus.timeout_err, (i >= TO) ? 1 : 0);
    end
    check("t6_idle", bus.active, 0);
    bus.req = 2'b01;
    step();
    check("t6_regrant", bus.tx_start, 1);
    check("t6_sticky", bus.timeout_err, 1);
    finish_frame();
`endif

    // Randomized requesters and transmitter
    apply_reset();
    auto_tx = 1;
    repeat (3000) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (bus.req[i] && bus.req_ack[i]) begin
          if ($urandom_range(0, 1) == 1) bus.req[i] = 1'b0;
          else bus.req_data[8*i +: 8] = 8'($urandom);
        end else if (!bus.req[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            bus.req[i]             = 1'b1;
            bus.req_data[8*i +: 8] = 8'($urandom);
          end
        end else if ($urandom_range(0, 31) == 0) begin
          bus.req[i] = 1'b0;
        end
      end
    end
    bus.req = '0;
    repeat (30) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
